// File: rtl/pasta_pkg.sv
// Shared PASTA datapath definitions: residue width, modulus, state size and the
// combinational modular adder used by every stage that sums residues.
package pasta_pkg;

  localparam int BITLEN  = 17;
  localparam int Q       = 65537;
  localparam int PASTA_S = 32;

  typedef logic [BITLEN-1:0] residue_t;

  localparam logic [BITLEN:0] Q_EXT = (BITLEN + 1)'(Q);

  // One carry bit of headroom, then a single conditional subtract of Q.
  function automatic residue_t modadd(input residue_t a, input residue_t b);
    logic [BITLEN:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= Q_EXT) begin
      modadd = residue_t'(s - Q_EXT);
    end else begin
      modadd = residue_t'(s);
    end
  endfunction

endpackage

// File: rtl/modadd_reg.sv
// One reduction-tree node: modular add of two residues, registered together with
// the beat's valid and last qualifiers.
module modadd_reg
  import pasta_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_valid,
  input  logic     in_last,
  input  residue_t a,
  input  residue_t b,
  output logic     out_valid,
  output logic     out_last,
  output residue_t out_data
);

  // Node register; data is captured every cycle, only valid/last qualify it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      out_last  <= in_valid & in_last;
      out_data  <= modadd(a, b);
    end
  end

endmodule

// File: rtl/modadd_tree_acc.sv
// Registered input stage, LANES-input pipelined modular adder tree and a beat
// accumulator that emits one coefficient sum mod Q per last beat.
module modadd_tree_acc
  import pasta_pkg::*;
#(
  parameter int BITLEN = 17,
  parameter int Q      = 65537,
  parameter int LANES  = 32,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [BITLEN*LANES-1:0] in_data,
  output logic                    out_valid,
  output logic [BITLEN-1:0]       out_data,
  output logic [CNT_W-1:0]        out_beats,
  output logic                    in_err
);

  localparam int NODES = 2 * LANES;

  // Heap-ordered tree: node n sums children 2n and 2n+1, leaves sit at LANES..NODES-1.
  logic [BITLEN-1:0] node_data  [1:NODES-1];
  logic              node_valid [1:NODES-1];
  logic              node_last  [1:NODES-1];

  logic [BITLEN-1:0] lane_r [LANES];
  logic              vld_r;
  logic              lst_r;
  logic              bad_s;

  logic [BITLEN-1:0] acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [BITLEN-1:0] acc_sum_s;
  logic [CNT_W-1:0]  cnt_inc_s;

  // Flags any lane outside 0..Q-1 on the incoming beat.
  always_comb begin
    bad_s = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      bad_s = bad_s | (in_data[i*BITLEN +: BITLEN] >= BITLEN'(Q));
    end
  end

  // Input register stage feeding the tree leaves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_r <= 1'b0;
      lst_r <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        lane_r[i] <= '0;
      end
    end else begin
      vld_r <= in_valid;
      lst_r <= in_valid & in_last;
      for (int i = 0; i < LANES; i++) begin
        lane_r[i] <= in_data[i*BITLEN +: BITLEN];
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_leaf
    assign node_data[LANES+i]  = lane_r[i];
    assign node_valid[LANES+i] = vld_r;
    assign node_last[LANES+i]  = lst_r;
  end

  for (genvar n = 1; n < LANES; n++) begin : g_node
    modadd_reg u_add (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (node_valid[2*n] & node_valid[2*n+1]),
      .in_last  (node_last[2*n] & node_last[2*n+1]),
      .a        (node_data[2*n]),
      .b        (node_data[2*n+1]),
      .out_valid(node_valid[n]),
      .out_last (node_last[n]),
      .out_data (node_data[n])
    );
  end

  assign acc_sum_s = modadd(acc_r, node_data[1]);
  assign cnt_inc_s = cnt_r + CNT_W'(1);

  // Accumulator, result register and sticky contract-violation flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r     <= '0;
      cnt_r     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
      in_err    <= 1'b0;
    end else begin
      in_err    <= in_err | (in_valid & bad_s);
      out_valid <= 1'b0;
      if (node_valid[1]) begin
        if (node_last[1]) begin
          out_data  <= acc_sum_s;
          out_beats <= cnt_inc_s;
          out_valid <= 1'b1;
          acc_r     <= '0;
          cnt_r     <= '0;
        end else begin
          acc_r <= acc_sum_s;
          cnt_r <= cnt_inc_s;
        end
      end else begin
        acc_r <= acc_r;
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_modadd_tree_acc.sv
// Self-checking bench: directed scenarios plus random traffic compared cycle by
// cycle against an arithmetic model of beat sums, accumulation and latency.
module tb_modadd_tree_acc;

  localparam int BITLEN = 17;
  localparam int Q      = 65537;
  localparam int LANES  = 32;
  localparam int CNT_W  = 8;
  localparam int DW     = BITLEN * LANES;
  localparam int LAT    = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_last;
  logic [DW-1:0]     in_data;
  logic              out_valid;
  logic [BITLEN-1:0] out_data;
  logic [CNT_W-1:0]  out_beats;
  logic              in_err;

  always #5 clk = ~clk;

  modadd_tree_acc #(.BITLEN(BITLEN), .Q(Q), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_beats(out_beats),
    .in_err   (in_err)
  );

  typedef struct {
    int due;
    int data;
    int beats;
    bit known;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_m = 0;
  int   cnt_m = 0;
  bit   acc_bad = 1'b0;
  bit   err_m = 1'b0;
  int   held_data = 0;
  int   held_beats = 0;
  bit   held_known = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill(input int val);
    logic [DW-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*BITLEN +: BITLEN] = BITLEN'(val);
    return d;
  endfunction

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] d;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 7))
        0:       d[i*BITLEN +: BITLEN] = '0;
        1:       d[i*BITLEN +: BITLEN] = BITLEN'(Q - 1);
        default: d[i*BITLEN +: BITLEN] = BITLEN'($urandom_range(0, Q - 1));
      endcase
    end
    return d;
  endfunction

  // One clock: drive, update the model at the edge, check outputs on the falling edge.
  task automatic tick(input bit r, input bit v, input bit l, input logic [DW-1:0] d);
    int   s;
    bit   bad;
    int   lv;
    exp_t e;
    rst_n    = r;
    in_valid = v;
    in_last  = l;
    in_data  = d;
    @(posedge clk);
    cyc++;
    if (!r) begin
      q.delete();
      acc_m = 0; cnt_m = 0; acc_bad = 1'b0; err_m = 1'b0;
      held_data = 0; held_beats = 0; held_known = 1'b1;
    end else if (v) begin
      s = 0; bad = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        lv = int'(d[i*BITLEN +: BITLEN]);
        if (lv >= Q) bad = 1'b1;
        s += lv;
      end
      if (bad) begin
        err_m = 1'b1;
        acc_bad = 1'b1;
      end
      acc_m = (acc_m + s) % Q;
      cnt_m++;
      if (l) begin
        e.due = cyc + LAT;
        e.data = acc_m;
        e.beats = cnt_m % (1 << CNT_W);
        e.known = !acc_bad;
        q.push_back(e);
        acc_m = 0; cnt_m = 0; acc_bad = 1'b0;
      end
    end
    @(negedge clk);
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check("out_valid_pulse", 32'(out_valid), 32'd1);
      held_data = e.data; held_beats = e.beats; held_known = e.known;
    end else begin
      check("out_valid_idle", 32'(out_valid), 32'd0);
    end
    if (held_known) check("out_data", 32'(out_data), 32'(held_data));
    check("out_beats", 32'(out_beats), 32'(held_beats));
    check("in_err", 32'(in_err), 32'(err_m));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    logic [DW-1:0] d;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, '0);

    tick(1'b1, 1'b1, 1'b1, fill(1));
    idle(8);
    check("single_beat_sum32", 32'(out_data), 32'd32);
    check("single_beat_beats", 32'(out_beats), 32'd1);

    tick(1'b1, 1'b1, 1'b1, fill(65536));
    idle(8);
    check("neg_sum_65505", 32'(out_data), 32'd65505);

    tick(1'b1, 1'b1, 1'b0, fill(2048));
    idle(3);
    tick(1'b1, 1'b1, 1'b1, fill(2048));
    idle(8);
    check("gap_sum_65535", 32'(out_data), 32'd65535);
    check("gap_beats_2", 32'(out_beats), 32'd2);

    for (int k = 0; k < 10; k++) tick(1'b1, 1'b1, 1'b1, fill(k));
    idle(8);

    tick(1'b1, 1'b1, 1'b0, fill(5));
    tick(1'b0, 1'b0, 1'b0, '0);
    idle(8);
    tick(1'b1, 1'b1, 1'b1, fill(1));
    idle(8);
    check("post_reset_sum32", 32'(out_data), 32'd32);

    for (int k = 0; k < 259; k++) tick(1'b1, 1'b1, 1'b0, rnd_beat());
    tick(1'b1, 1'b1, 1'b1, rnd_beat());
    idle(8);
    check("cnt_wrap_beats", 32'(out_beats), 32'd4);

    for (int k = 0; k < 150; k++) begin
      tick(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), rnd_beat());
    end
    tick(1'b1, 1'b1, 1'b1, rnd_beat());
    idle(8);

    d = fill(0);
    d[BITLEN-1:0] = BITLEN'(Q);
    tick(1'b1, 1'b1, 1'b1, d);
    check("err_set_next_cycle", 32'(in_err), 32'd1);
    tick(1'b1, 1'b1, 1'b0, fill(3));
    tick(1'b1, 1'b1, 1'b1, fill(4));
    idle(10);
    check("err_sticky", 32'(in_err), 32'd1);
    check("after_err_sum", 32'(out_data), 32'd224);
    tick(1'b0, 1'b0, 1'b0, '0);
    check("err_cleared", 32'(in_err), 32'd0);
    tick(1'b1, 1'b1, 1'b1, fill(7));
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/modadd_tree_acc.md
# modadd_tree_acc

Pipelined modular reduction stage that consumes the 32 lane products emitted each cycle by the PASTA modular-multiply stage and sums them mod q = 65537. It can also accumulate that sum across several beats, which forms one output coefficient of the affine-layer matrix-vector product. The block sits directly downstream of the modular-multiply stage (pipeline stage 3) and feeds the round-constant / S-box stage.

## Interface
- Parameters:
  - BITLEN, 17: residue width.
  - Q, 65537: modulus.
  - LANES, 32: input lanes. Must be a power of two.
  - CNT_W, 8: beat-counter width.
- Ports:
  - clk, in, 1: single clock; all logic is on the rising edge.
  - rst_n, in, 1: synchronous, active-low reset.
  - in_valid, in, 1: in_data beat valid this cycle.
  - in_last, in, 1: qualified by in_valid; this beat closes the current accumulation.
  - in_data, in, BITLEN*LANES: lane i occupies bits [BITLEN*(i+1)-1 : BITLEN*i]; each lane is a residue in 0..Q-1.
  - out_valid, out, 1: one-cycle pulse when a result is available.
  - out_data, out, BITLEN: accumulated sum mod Q; holds its value between pulses.
  - out_beats, out, CNT_W: number of beats in the reported result; wraps mod 2^CNT_W.
  - in_err, out, 1: sticky flag; set when any lane of a valid beat is ≥ Q.

## Operation
- No backpressure. A beat is accepted every cycle in which in_valid=1.
- Reduction tree:
  - log2(LANES) = 5 levels of pairwise modular adds, with a register after each level.
  - Each level carries a valid bit and a last bit alongside the data.
- Modular add: s = a + b computed in BITLEN+1 bits; the result is s − Q if s ≥ Q, else s. Inputs and outputs are always in 0..Q-1 when inputs are in contract.
- Accumulator stage, driven by the tree output (valid, last, sum):
  - valid & !last: acc ← modadd(acc, sum); cnt ← cnt+1.
  - valid & last: out_data ← modadd(acc, sum); out_beats ← cnt+1; out_valid ← 1; then acc ← 0 and cnt ← 0.
  - !valid: acc and cnt hold; out_valid ← 0.
- A single-beat accumulation (in_last on the first beat) yields the tree sum with out_beats = 1.
- in_err:
  - Set in the cycle after acceptance of any beat with a lane ≥ Q.
  - Cleared only by reset.
  - Data from out-of-contract lanes is processed unchecked; the result is unspecified but the block must not hang.
- Reset (rst_n=0 at a clock edge) clears all of the following: the pipeline valid bits, acc, cnt, out_valid, out_data, out_beats and in_err. Any in-flight beats and any partial accumulation are discarded.

## Timing
- Latency: a last beat accepted at edge t produces out_valid high in the cycle after edge t+6 (6 cycles: 5 tree levels plus the accumulator stage).
- Throughput: 1 beat per cycle. Back-to-back last beats produce back-to-back out_valid pulses.
- Bubbles (in_valid=0) propagate through the tree and leave the accumulator unchanged. Gaps between beats of one accumulation are legal.
- Reset values: out_valid=0, out_data=0, out_beats=0, in_err=0.
- Deasserting rst_n mid-stream means beats accepted before the reset edge never appear at the output. Beats accepted on or after the first edge with rst_n=1 are processed normally.
- The cnt wrap at 2^CNT_W is silent; the accumulation continues.

## Structure
- Shared package pasta_pkg: BITLEN=17, Q=65537, PASTA_S=32, and a residue_t typedef (logic [BITLEN-1:0]). This is shared with the modular-multiply and downstream stages.
- Sub-module modadd_reg: one modular adder followed by a data/valid/last register with synchronous active-low reset.
  - The tree instantiates it LANES-1 times via generate.
  - The accumulator reuses its combinational add.

## Test plan
- All lanes = 1, one beat with in_last=1 → out_valid 6 cycles later, out_data=32, out_beats=1.
- All lanes = 65536, one last beat → out_data=65505 (= −32 mod Q).
- Two beats of all lanes = 2048, second with in_last, separated by a 3-cycle bubble → out_data=65535, out_beats=2, exactly one out_valid pulse.
- Continuous last beats with lane values 0, 1, 2… (lane i = beat index) on consecutive cycles → consecutive out_valid pulses with out_data = 32·k mod Q for beat k.
- rst_n low for 1 cycle after beat 1 of a 3-beat accumulation → no output from the aborted beats; a following single last beat of all 1s → out_data=32, out_beats=1.
- One beat with lane 0 = 65537 → in_err=1 the next cycle and stays high until reset; a subsequent in-contract accumulation still produces out_valid.
